// File: rtl/wake_ctrl.sv
// Activation gating and wake decision: synchronizes the activate pin, enables the
// front end once configured, majority-votes inference results and emits a held wake.
module wake_ctrl #(
  parameter int VOTE_WIN       = 4,
  parameter int VOTE_THRESH    = 2,
  parameter int HOLD_CYCLES    = 1000,
  parameter int REFRACT_CYCLES = 4000,
  parameter int CNT_BW         = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       activate_i,
  input  logic       cfg_ready_i,
  input  logic       wrd_wake_i,
  input  logic       wrd_wake_valid_i,
  output logic       frontend_en_o,
  output logic       wake_o,
  output logic [1:0] state_o,
  output logic [7:0] wake_count_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, LISTEN = 2'd1, WAKE = 2'd2, REFRACT = 2'd3} state_t;

  localparam logic [CNT_BW-1:0] HOLD_LD = CNT_BW'(HOLD_CYCLES - 1);
  localparam logic [CNT_BW-1:0] REF_LD  = CNT_BW'(REFRACT_CYCLES - 1);
  localparam logic [CNT_BW-1:0] ONE     = CNT_BW'(1);

  state_t              state, state_n;
  logic                act_m, act_s, active;
  logic [VOTE_WIN-1:0] win, win_n, win_sh;
  logic [CNT_BW-1:0]   cnt, cnt_n;
  logic [7:0]          wcnt, wcnt_n;

  function automatic int popcnt(input logic [VOTE_WIN-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < VOTE_WIN; i++) c += int'(v[i]);
    return c;
  endfunction

  assign active = act_s & cfg_ready_i;
  // Newest result enters at bit 0; the oldest falls off the top.
  assign win_sh = VOTE_WIN'({win, wrd_wake_i});

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    win_n   = win;
    wcnt_n  = wcnt;
    case (state)
      IDLE: begin
        if (active) begin
          state_n = LISTEN;
          win_n   = '0;
        end
      end
      LISTEN: begin
        if (!active) begin
          state_n = IDLE;
        end else if (wrd_wake_valid_i) begin
          win_n = win_sh;
          if (popcnt(win_sh) >= VOTE_THRESH) begin
            state_n = WAKE;
            cnt_n   = HOLD_LD;
            win_n   = '0;
            wcnt_n  = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
          end
        end
      end
      WAKE: begin
        // Hold is never truncated; deactivation is only honoured once it ends.
        if (cnt == '0) begin
          if (active) begin
            state_n = REFRACT;
            cnt_n   = REF_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - ONE;
        end
      end
      REFRACT: begin
        win_n = '0;
        if (!active)         state_n = IDLE;
        else if (cnt == '0)  state_n = LISTEN;
        else                 cnt_n = cnt - ONE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_m         <= 1'b0;
      act_s         <= 1'b0;
      state         <= IDLE;
      win           <= '0;
      cnt           <= '0;
      wcnt          <= '0;
      frontend_en_o <= 1'b0;
      wake_o        <= 1'b0;
    end else begin
      act_m         <= activate_i;
      act_s         <= act_m;
      state         <= state_n;
      win           <= win_n;
      cnt           <= cnt_n;
      wcnt          <= wcnt_n;
      frontend_en_o <= (state_n != IDLE);
      wake_o        <= (state_n == WAKE);
    end
  end

  assign state_o      = state;
  assign wake_count_o = wcnt;

endmodule

// File: tb/tb_wake_ctrl.sv
// Directed bench for wake_ctrl with shortened hold/refractory periods.
module tb_wake_ctrl;
  localparam int HOLD = 20;
  localparam int REFR = 50;

  logic       clk = 1'b0;
  logic       rst, act, cfg, res, vld;
  logic       fe, wk;
  logic [1:0] st;
  logic [7:0] wcnt;
  int         errs = 0, chks = 0;

  wake_ctrl #(.VOTE_WIN(4), .VOTE_THRESH(2), .HOLD_CYCLES(HOLD),
              .REFRACT_CYCLES(REFR), .CNT_BW(16)) dut (
    .clk_i(clk), .rst_i(rst), .activate_i(act), .cfg_ready_i(cfg),
    .wrd_wake_i(res), .wrd_wake_valid_i(vld), .frontend_en_o(fe),
    .wake_o(wk), .state_o(st), .wake_count_o(wcnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    chks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic r);
    vld = 1'b1; res = r;
    step();
    vld = 1'b0; res = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    int n = 0;
    while (int'(st) != s && n < budget) begin step(); n++; end
    chk(tag, int'(st), s);
  endtask

  // Counts consecutive cycles wake_o stays high, starting on a cycle where it is high.
  task automatic hold_len(output int n);
    n = 0;
    while (wk && n < 10 * HOLD) begin step(); n++; end
  endtask

  initial begin
    int n;
    rst = 1'b1; act = 1'b1; cfg = 1'b0; res = 1'b0; vld = 1'b0;
    repeat (3) step();
    chk("reset_state", int'(st), 0);
    chk("reset_wake", int'(wk), 0);
    chk("reset_count", int'(wcnt), 0);
    rst = 1'b0;
    repeat (20) step();
    chk("gate_state", int'(st), 0);
    chk("gate_fe", int'(fe), 0);
    cfg = 1'b1;
    step();
    chk("cfg_state", int'(st), 1);
    chk("cfg_fe", int'(fe), 1);

    // vote 1,0,0,1 -> wake right after the fourth pulse
    pulse(1); pulse(0); pulse(0);
    chk("vote_pre", int'(wk), 0);
    pulse(1);
    chk("vote_wake", int'(wk), 1);
    chk("vote_state", int'(st), 2);
    chk("vote_count", int'(wcnt), 1);
    hold_len(n);
    chk("hold_len", n, HOLD);
    chk("refr_state", int'(st), 3);
    n = 0;
    while (st == 2'd3 && n < 10 * REFR) begin step(); n++; end
    chk("refr_len", n, REFR);
    chk("refr_exit", int'(st), 1);

    // window aging: 1,0,0,0,1 never reaches two ones
    pulse(1); pulse(0); pulse(0); pulse(0); pulse(1);
    chk("age_nowake", int'(wk), 0);
    pulse(1);
    chk("age_wake", int'(wk), 1);
    chk("age_count", int'(wcnt), 2);
    wait_state("age_back", 1, HOLD + REFR + 10);

    // refractory ignore
    pulse(1); pulse(1);
    chk("ri_count", int'(wcnt), 3);
    wait_state("ri_refr", 3, HOLD + 10);
    repeat (10) pulse(1);
    chk("ri_state", int'(st), 3);
    chk("ri_wake", int'(wk), 0);
    wait_state("ri_back", 1, REFR + 10);
    pulse(1);
    chk("ri_single", int'(st), 1);

    // deactivate beats a same-cycle trigger (window already holds one positive)
    act = 1'b0;
    step(); step();
    pulse(1);
    chk("dp_state", int'(st), 0);
    chk("dp_wake", int'(wk), 0);
    chk("dp_count", int'(wcnt), 3);

    // drop during WAKE keeps the full hold, then IDLE directly
    act = 1'b1;
    wait_state("dw_listen", 1, 10);
    pulse(1); pulse(1);
    act = 1'b0;
    hold_len(n);
    chk("dw_hold", n, HOLD);
    chk("dw_idle", int'(st), 0);
    chk("dw_count", int'(wcnt), 4);

    // reset mid-hold
    act = 1'b1;
    wait_state("rm_listen", 1, 10);
    pulse(1); pulse(1);
    repeat (HOLD / 2 - 1) step();
    chk("rm_inhold", int'(wk), 1);
    rst = 1'b1;
    step();
    chk("rm_wake", int'(wk), 0);
    chk("rm_state", int'(st), 0);
    chk("rm_count", int'(wcnt), 0);
    chk("rm_fe", int'(fe), 0);
    rst = 1'b0;

    // saturation after 300 wakes
    wait_state("sat_listen", 1, 10);
    for (int i = 0; i < 300; i++) begin
      pulse(1); pulse(1);
      n = 0;
      while (st != 2'd1 && n < HOLD + REFR + 10) begin step(); n++; end
      if (n >= HOLD + REFR + 10) begin
        chk("sat_timeout", int'(st), 1);
        break;
      end
    end
    chk("sat_count", int'(wcnt), 255);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule

// File: doc/wake_ctrl.md
Name: wake_ctrl

Overview:
Activation and wake-decision controller between the word recognizer (wrd) and the chip pins. It synchronizes the external activate pin and gates the front end (dfe/aco enable) until configuration is complete. It majority-votes successive wrd inference results and produces a held wake pulse, followed by a refractory lockout. It occupies the en_i hookup of dfe/aco and drives the top-level wake_o.

Parameters:
VOTE_WIN, 4, number of most recent inference results kept in the vote window (1..8)
VOTE_THRESH, 2, minimum positive results in window to trigger wake (1..VOTE_WIN)
HOLD_CYCLES, 1000, cycles wake_o stays high per wake event (>=1)
REFRACT_CYCLES, 4000, cycles after hold during which results are ignored (>=1)
CNT_BW, 16, width of hold/refractory counter (must hold max(HOLD_CYCLES, REFRACT_CYCLES))

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
activate_i  input  1  external activate pin, asynchronous to clk_i
cfg_ready_i  input  1  level; high once weight memories are loaded
wrd_wake_i  input  1  inference result, sampled only when wrd_wake_valid_i=1
wrd_wake_valid_i  input  1  single-cycle pulse, one per completed inference
frontend_en_o  output  1  enable to dfe and aco
wake_o  output  1  wake pin
state_o  output  2  current state: 0 IDLE, 1 LISTEN, 2 WAKE, 3 REFRACT
wake_count_o  output  8  saturating count of wake events since reset

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state IDLE; frontend_en_o=0; wake_o=0; wake_count_o=0; vote window=0; counter=0; both sync flops=0.
- Reset mid-operation: any state goes to IDLE on the next edge. wake_o drops that edge regardless of hold progress.
- activate_i passes through a 2-flop synchronizer; act_s is the second flop. A toggle on activate_i reaches act_s after 2 edges.
- All outputs are registered.
- frontend_en_o=1 exactly when state is LISTEN, WAKE or REFRACT.
- wake_o=1 exactly when state is WAKE.
- IDLE: go to LISTEN when act_s=1 and cfg_ready_i=1. The vote window is cleared on entry.
- LISTEN:
  - If act_s=0 or cfg_ready_i=0, go to IDLE.
  - Else, on wrd_wake_valid_i, the window shifts in wrd_wake_i (oldest dropped).
  - If popcount(new window) >= VOTE_THRESH, go to WAKE next edge. Counter loads HOLD_CYCLES-1, wake_count_o increments (saturates at 255), window clears.
  - Deactivate has priority over a same-cycle trigger: go to IDLE, no wake, no count change.
- WAKE:
  - Counter decrements each cycle. At 0, go to REFRACT with counter loaded REFRACT_CYCLES-1.
  - wake_o is high for exactly HOLD_CYCLES consecutive cycles.
  - act_s=0 or cfg_ready_i=0 does NOT truncate the hold.
  - wrd_wake_valid_i is ignored.
- REFRACT:
  - Counter decrements. wrd_wake_valid_i is ignored and the window stays zero.
  - If act_s=0 or cfg_ready_i=0, go to IDLE immediately.
  - At counter 0: go to LISTEN if still active, else IDLE.
- Latency: valid pulse at edge t that meets threshold gives wake_o=1 from edge t+1. Activate rise gives frontend_en_o=1 three edges later (2 sync + 1 state), given cfg_ready_i=1.
- Partial window: fewer than VOTE_WIN results since entry count as zeros. With VOTE_THRESH=1, the first positive triggers.
- Counter widths: no arithmetic wrap. The counter never decrements below 0 and loads only on state entry.

Test Plan:
- Power-up gating: rst_i 3 cycles, activate_i=1, cfg_ready_i=0 for 20 cycles -> state_o=0, frontend_en_o=0. Raise cfg_ready_i -> state_o=1 and frontend_en_o=1 one edge later.
- Vote trigger (defaults): valid pulses with results 1,0,0,1 -> wake_o rises the edge after the 4th pulse. It stays high exactly 1000 cycles, wake_count_o=1, then state_o=3 for 4000 cycles, then 1.
- Window aging: results 1,0,0,0,1 -> no wake (popcount never reaches 2). A further 1 -> wake.
- Refractory ignore: 10 positive pulses during REFRACT -> no wake, and the window is 0 on return to LISTEN. A single positive after return -> no wake.
- Deactivate priority: activate_i drop timed so act_s=0 on the same edge as a threshold-meeting pulse -> state_o=0, wake_o=0, wake_count_o unchanged. A drop during WAKE -> full 1000-cycle hold, then IDLE directly.
- Reset mid-WAKE: rst_i at hold cycle 500 -> next edge wake_o=0, state_o=0, wake_count_o=0, frontend_en_o=0. Saturation: 300 wake events -> wake_count_o=255.
